// File: rtl/memory_responder_if.sv
// memory_responder_if: CPU-side bus carrying both memory ports of memory_responder.
interface memory_responder_if #(
    parameter int WORD_SIZE = 16
);
    logic                 readM1;
    logic [WORD_SIZE-1:0] address1;
    logic [WORD_SIZE-1:0] data1;
    logic                 ack1;
    logic                 readM2;
    logic                 writeM2;
    logic [WORD_SIZE-1:0] address2;
    logic [WORD_SIZE-1:0] data2;
    logic [WORD_SIZE-1:0] rdata2;
    logic                 ack2;
    logic                 protocol_err;
    modport master (
        output readM1, address1, readM2, writeM2, address2, data2,
        input  data1, ack1, rdata2, ack2, protocol_err
    );
    modport slave (
        input  readM1, address1, readM2, writeM2, address2, data2,
        output data1, ack1, rdata2, ack2, protocol_err
    );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: shared word memory behind a read-only port 1 and a read/write port 2,
// each with its own request/ack FSM and fixed access latency.
module memory_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    memory_responder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [WORD_SIZE-1:0] r_mem [2**ADDR_BITS];

    state_t               r_st1;
    logic [3:0]           r_cnt1;
    logic [ADDR_BITS-1:0] r_addr1;
    logic [WORD_SIZE-1:0] r_data1;
    logic                 r_ack1;

    state_t               r_st2;
    logic [3:0]           r_cnt2;
    logic [ADDR_BITS-1:0] r_addr2;
    logic [WORD_SIZE-1:0] r_wdata2;
    logic [WORD_SIZE-1:0] r_rdata2;
    logic                 r_wr2;
    logic                 r_ack2;
    logic                 r_perr;

    logic                 w_req2;
    logic                 w_we2;

    assign w_req2 = bus.readM2 | bus.writeM2;
    // Commit happens on the WAIT->RESP edge only, so an abort or reset drops the write.
    assign w_we2  = r_st2 == S_WAIT && w_req2 && r_cnt2 == 4'd0 && r_wr2;

    always_ff @(posedge clk) begin
        if (w_we2) r_mem[r_addr2] <= r_wdata2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st1   <= S_IDLE;
            r_cnt1  <= '0;
            r_addr1 <= '0;
            r_data1 <= '0;
            r_ack1  <= 1'b0;
        end else begin
            case (r_st1)
                S_IDLE: if (bus.readM1) begin
                    r_addr1 <= bus.address1[ADDR_BITS-1:0];
                    r_cnt1  <= CNT_INIT;
                    r_st1   <= S_WAIT;
                end
                S_WAIT: if (!bus.readM1) begin
                    r_st1 <= S_IDLE;
                end else if (r_cnt1 == 4'd0) begin
                    r_st1   <= S_RESP;
                    r_ack1  <= 1'b1;
                    r_data1 <= r_mem[r_addr1];
                end else begin
                    r_cnt1 <= r_cnt1 - 4'd1;
                end
                S_RESP: begin
                    r_ack1 <= 1'b0;
                    r_st1  <= S_IDLE;
                end
                default: r_st1 <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st2    <= S_IDLE;
            r_cnt2   <= '0;
            r_addr2  <= '0;
            r_wdata2 <= '0;
            r_rdata2 <= '0;
            r_wr2    <= 1'b0;
            r_ack2   <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            case (r_st2)
                S_IDLE: if (w_req2) begin
                    r_addr2  <= bus.address2[ADDR_BITS-1:0];
                    r_wr2    <= bus.writeM2;
                    r_wdata2 <= bus.data2;
                    r_cnt2   <= CNT_INIT;
                    r_st2    <= S_WAIT;
                    if (bus.readM2 && bus.writeM2) r_perr <= 1'b1;
                end
                S_WAIT: if (!w_req2) begin
                    r_st2 <= S_IDLE;
                end else if (r_cnt2 == 4'd0) begin
                    r_st2  <= S_RESP;
                    r_ack2 <= 1'b1;
                    if (!r_wr2) r_rdata2 <= r_mem[r_addr2];
                end else begin
                    r_cnt2 <= r_cnt2 - 4'd1;
                end
                S_RESP: begin
                    r_ack2 <= 1'b0;
                    r_st2  <= S_IDLE;
                end
                default: r_st2 <= S_IDLE;
            endcase
        end
    end

    assign bus.data1        = r_data1;
    assign bus.ack1         = r_ack1;
    assign bus.rdata2       = r_rdata2;
    assign bus.ack2         = r_ack2;
    assign bus.protocol_err = r_perr;
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: three responders (LATENCY 1, 2, 4) driven one after another
// with directed and random traffic, checked against a word-array reference model.
module tb_memory_responder;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset [3];
    logic         rd1   [3];
    logic         rd2   [3];
    logic         wr2   [3];
    logic [W-1:0] a1    [3];
    logic [W-1:0] a2    [3];
    logic [W-1:0] d2    [3];
    logic         ack1  [3];
    logic         ack2  [3];
    logic         perr  [3];
    logic [W-1:0] q1    [3];
    logic [W-1:0] q2    [3];

    for (genvar g = 0; g < 3; g++) begin : g_lane
        memory_responder_if #(.WORD_SIZE(W)) bus ();
        assign bus.readM1   = rd1[g];
        assign bus.address1 = a1[g];
        assign bus.readM2   = rd2[g];
        assign bus.writeM2  = wr2[g];
        assign bus.address2 = a2[g];
        assign bus.data2    = d2[g];
        assign ack1[g]      = bus.ack1;
        assign ack2[g]      = bus.ack2;
        assign perr[g]      = bus.protocol_err;
        assign q1[g]        = bus.data1;
        assign q2[g]        = bus.rdata2;
        memory_responder #(
            .WORD_SIZE(W),
            .ADDR_BITS(8),
            .LATENCY  (g == 0 ? 1 : (g == 1 ? 2 : 4))
        ) dut (
            .clk  (clk),
            .reset(reset[g]),
            .bus  (bus)
        );
    end

    int           checks = 0;
    int           failures = 0;
    int           ln;
    int           lat;
    logic [W-1:0] model [256];
    logic [W-1:0] last1;
    logic [W-1:0] last2;
    logic         mperr;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s lane_lat=%0d got=%h exp=%h", tag, lat, got, exp);
        end
    endtask

    task automatic idle_lane();
        rd1[ln] = 1'b0;
        rd2[ln] = 1'b0;
        wr2[ln] = 1'b0;
    endtask

    // One access slot: optional port-1 read and port-2 op accepted on the same edge;
    // abort_at >= 0 drops the port-2 request that many cycles after accept.
    task automatic txn(input bit do1, input logic [W-1:0] x1, input bit r2, input bit w2,
                       input logic [W-1:0] x2, input logic [W-1:0] dd, input int abort_at);
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        bit           do2;
        bit           done2;
        do2   = r2 | w2;
        done2 = do2 && abort_at < 0;
        e1    = model[x1[7:0]];
        e2    = model[x2[7:0]];
        @(negedge clk);
        rd1[ln] = do1;
        a1[ln]  = x1;
        rd2[ln] = r2;
        wr2[ln] = w2;
        a2[ln]  = x2;
        d2[ln]  = dd;
        if (r2 && w2) mperr = 1'b1;
        for (int c = 0; c <= lat + 1; c++) begin
            @(posedge clk);
            #1;
            if (c == lat) begin
                if (do1) last1 = e1;
                if (done2 && !w2) last2 = e2;
            end
            check("ack1", 16'(ack1[ln]), 16'(do1 && c == lat));
            check("ack2", 16'(ack2[ln]), 16'(done2 && c == lat));
            check("perr", 16'(perr[ln]), 16'(mperr));
            check("data1", q1[ln], last1);
            check("rdata2", q2[ln], last2);
            if (c == abort_at) begin
                rd2[ln] = 1'b0;
                wr2[ln] = 1'b0;
            end
            if (c == lat) idle_lane();
        end
        if (w2 && abort_at < 0) model[x2[7:0]] = dd;
    endtask

    task automatic reset_mid(input int j);
        @(negedge clk);
        wr2[ln] = 1'b1;
        a2[ln]  = 16'h0021;
        d2[ln]  = ~model[8'h21];
        @(posedge clk);
        #1;
        repeat (j) begin
            @(posedge clk);
            #1;
        end
        reset[ln] = 1'b1;
        #1;
        check("rst_ack2", 16'(ack2[ln]), 16'h0);
        check("rst_data1", q1[ln], 16'h0);
        check("rst_rdata2", q2[ln], 16'h0);
        check("rst_perr", 16'(perr[ln]), 16'h0);
        idle_lane();
        @(posedge clk);
        #1;
        check("rst_hold_ack2", 16'(ack2[ln]), 16'h0);
        @(negedge clk);
        reset[ln] = 1'b0;
        last1 = '0;
        last2 = '0;
        mperr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog lane_lat=%0d", lat);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] x1;
        logic [W-1:0] x2;
        int           op;
        int           ab;
        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b0;
            rd1[i] = 1'b0;
            rd2[i] = 1'b0;
            wr2[i] = 1'b0;
            a1[i] = '0;
            a2[i] = '0;
            d2[i] = '0;
        end
        #2;
        for (int i = 0; i < 3; i++) reset[i] = 1'b1;
        for (int l = 0; l < 3; l++) begin
            ln    = l;
            lat   = l == 0 ? 1 : (l == 1 ? 2 : 4);
            last1 = '0;
            last2 = '0;
            mperr = 1'b0;
            @(negedge clk);
            check("reset_ack1", 16'(ack1[ln]), 16'h0);
            check("reset_ack2", 16'(ack2[ln]), 16'h0);
            check("reset_data1", q1[ln], 16'h0);
            check("reset_rdata2", q2[ln], 16'h0);
            check("reset_perr", 16'(perr[ln]), 16'h0);
            reset[ln] = 1'b0;
            for (int a = 0; a < 64; a++) txn(0, '0, 0, 1, 16'(a), 16'($urandom), -1);
            txn(0, '0, 0, 1, 16'h0005, 16'h1234, -1);
            txn(1, 16'h0005, 0, 0, '0, '0, -1);
            check("t1_read", q1[ln], 16'h1234);
            txn(0, '0, 0, 1, 16'h0010, 16'hAAAA, -1);
            txn(1, 16'h0010, 0, 1, 16'h0010, 16'h5555, -1);
            check("t2_collide", q1[ln], 16'hAAAA);
            txn(1, 16'h0010, 0, 0, '0, '0, -1);
            check("t2_after", q1[ln], 16'h5555);
            txn(0, '0, 0, 1, 16'h0020, 16'h1111, -1);
            txn(0, '0, 0, 1, 16'h0020, 16'hBEEF, lat > 1 ? 1 : 0);
            txn(1, 16'h0020, 0, 0, '0, '0, -1);
            check("t3_abort", q1[ln], 16'h1111);
            txn(0, '0, 0, 1, 16'h0103, 16'h7777, -1);
            txn(1, 16'h0003, 0, 0, '0, '0, -1);
            check("t4_wrap", q1[ln], 16'h7777);
            txn(0, '0, 1, 1, 16'h0030, 16'h00FF, -1);
            check("t5_perr", 16'(perr[ln]), 16'h1);
            txn(0, '0, 1, 0, 16'h0030, '0, -1);
            check("t5_data", q2[ln], 16'h00FF);
            for (int n = 0; n < 40; n++) begin
                x1 = 16'($urandom) & 16'hFF3F;
                x2 = 16'($urandom) & 16'hFF3F;
                if ($urandom_range(0, 1) == 1) x2[7:0] = x1[7:0];
                op = $urandom_range(0, 7);
                ab = (op != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, lat - 1) : -1;
                txn(1'($urandom_range(0, 1)), x1, op == 1 || op == 2 || op == 7,
                    op >= 3, x2, 16'($urandom), ab);
            end
            reset_mid($urandom_range(0, lat - 1));
            txn(1, 16'h0021, 1, 0, 16'h0021, '0, -1);
            check("t6_nocommit", q2[ln], model[8'h21]);
            reset[ln] = 1'b1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
